// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a framed byte stream (LEN, data bytes MSB first,
// XOR checksum) into words written at sequential addresses while holding the CPU.
module imem_loader #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int BPW   = DATA_W / 8;
    localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t            state_q;
    logic              byte_ready_q, mem_we_q, cpu_hold_q, done_q, error_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] word_q;
    logic [ADDR_W:0]   words_q, n_q;
    logic [7:0]        csum_q;
    logic [BC_W-1:0]   bcnt_q;
    logic [TO_W-1:0]   tmo_q;

    logic              xfer, tmo_hit, len_bad, last_byte, last_word;
    logic [ADDR_W:0]   words_d;
    logic [7:0]        csum_d;
    logic [DATA_W-1:0] word_d;

    assign xfer      = byte_valid && byte_ready_q;
    assign tmo_hit   = (tmo_q == TO_W'(TIMEOUT - 1));
    assign len_bad   = (byte_data == 8'd0) || (int'(byte_data) > DEPTH);
    assign last_byte = (bcnt_q == BC_W'(BPW - 1));
    assign words_d   = words_q + (ADDR_W + 1)'(1);
    assign last_word = (words_d == n_q);
    assign csum_d    = csum_q ^ byte_data;
    assign word_d    = {word_q[DATA_W-9:0], byte_data};

    // All outputs are registered: each branch sets them for the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            addr_q       <= '0;
            word_q       <= '0;
            words_q      <= '0;
            n_q          <= '0;
            csum_q       <= '0;
            bcnt_q       <= '0;
            tmo_q        <= '0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q      <= S_LEN;
                        byte_ready_q <= 1'b1;
                        cpu_hold_q   <= 1'b1;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        words_q      <= '0;
                        csum_q       <= '0;
                        addr_q       <= '0;
                        bcnt_q       <= '0;
                        tmo_q        <= '0;
                    end
                end
                S_LEN, S_DATA, S_CSUM: begin
                    // A transfer on the timeout cycle still counts as progress.
                    if (xfer) begin
                        tmo_q <= '0;
                        if (state_q == S_LEN) begin
                            if (len_bad) begin
                                state_q      <= S_ERR;
                                byte_ready_q <= 1'b0;
                                error_q      <= 1'b1;
                            end else begin
                                n_q     <= (ADDR_W + 1)'(byte_data);
                                state_q <= S_DATA;
                            end
                        end else if (state_q == S_DATA) begin
                            word_q <= word_d;
                            csum_q <= csum_d;
                            if (last_byte) begin
                                bcnt_q       <= '0;
                                state_q      <= S_WRITE;
                                byte_ready_q <= 1'b0;
                                mem_we_q     <= 1'b1;
                            end else begin
                                bcnt_q <= bcnt_q + BC_W'(1);
                            end
                        end else if (byte_data == csum_q) begin
                            state_q      <= S_DONE;
                            byte_ready_q <= 1'b0;
                            cpu_hold_q   <= 1'b0;
                            done_q       <= 1'b1;
                        end else begin
                            state_q      <= S_ERR;
                            byte_ready_q <= 1'b0;
                            error_q      <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        state_q      <= S_ERR;
                        byte_ready_q <= 1'b0;
                        error_q      <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TO_W'(1);
                    end
                end
                S_WRITE: begin
                    words_q      <= words_d;
                    byte_ready_q <= 1'b1;
                    // Address holds on the final word so a full-depth load never wraps.
                    if (last_word) begin
                        state_q <= S_CSUM;
                    end else begin
                        state_q <= S_DATA;
                        addr_q  <= addr_q + ADDR_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign byte_ready = byte_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = word_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;
    assign words      = words_q;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame-level model predicts writes and final status.
module tb_imem_loader;
    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;
    localparam int DEPTH   = 64;

    typedef logic [7:0] bq_t[$];

    logic              clk = 1'b0;
    logic              reset, start, byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready, mem_we, cpu_hold, done, error;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W:0]   words;

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .done(done), .error(error), .words(words)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic        armed = 1'b0;
    logic        prev_we = 1'b0;
    logic [5:0]  exp_a[$];
    logic [31:0] exp_d[$];
    logic [31:0] tbmem[DEPTH];
    logic        exp_done, exp_err;
    int          exp_words;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Frame-level model: which words land where, and how the load ends.
    task automatic model(input bq_t fr);
        int n;
        logic [7:0] cs;
        n  = int'(fr[0]);
        cs = 8'h00;
        if (n == 0 || n > DEPTH) begin
            exp_done = 1'b0; exp_err = 1'b1; exp_words = 0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            exp_a.push_back(6'(i));
            exp_d.push_back({fr[1+4*i], fr[2+4*i], fr[3+4*i], fr[4+4*i]});
            for (int j = 1; j <= 4; j++) cs ^= fr[j+4*i];
        end
        exp_words = n;
        exp_done  = (fr[1+4*n] == cs);
        exp_err   = !exp_done;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            if (mem_we) begin
                tbmem[mem_addr] <= mem_wdata;
                chk("we_ready_low", byte_ready, 0);
                if (exp_a.size() == 0) chk("unexpected_we", 1, 0);
                else begin
                    chk("we_addr", mem_addr, exp_a.pop_front());
                    chk("we_data", mem_wdata, exp_d.pop_front());
                end
            end
            if (prev_we && !reset) chk("ready_after_we", byte_ready, 1);
            chk("done_err_excl", done && error, 0);
            prev_we <= mem_we;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        while (!byte_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (!byte_ready) chk("send_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input string nm, input bq_t fr, input int ign_start_at);
        int  n;
        logic ok;
        n  = int'(fr[0]);
        ok = (n >= 1 && n <= DEPTH);
        model(fr);
        pulse_start();
        chk({nm, "_hold_on_start"}, cpu_hold, 1);
        chk({nm, "_ready_on_start"}, byte_ready, 1);
        chk({nm, "_flags_clear"}, {done, error, words}, 0);
        for (int i = 0; i < fr.size(); i++) begin
            send_byte(fr[i]);
            if (ok && i >= 1 && i <= 4*n && (i % 4) == 0)
                chk({nm, "_we_latency"}, {mem_we, byte_ready}, 2'b10);
            if (i == ign_start_at) begin
                byte_valid = 1'b0;
                pulse_start();
            end
        end
        byte_valid = 1'b0;
        chk({nm, "_done"}, done, exp_done);
        chk({nm, "_error"}, error, exp_err);
        chk({nm, "_cpu_hold"}, cpu_hold, exp_err);
        chk({nm, "_words"}, words, exp_words);
        chk({nm, "_ready_idle"}, byte_ready, 0);
        chk({nm, "_writes_left"}, exp_a.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        bq_t fr;
        int  c;
        logic [7:0] cs;
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, words},
            0);
        reset = 1'b0;
        armed = 1'b1;

        // Test 1: the XOR of the eight data bytes is 0x44.
        fr = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};
        run_frame("t1", fr, -1);
        chk("t1_done_lit", done, 1);
        chk("t1_mem0_lit", tbmem[0], 32'h11223344);
        chk("t1_mem1_lit", tbmem[1], 32'hAABBCCDD);

        // Test 2: bad checksum, words still written.
        fr[9] = 8'h45;
        run_frame("t2", fr, -1);
        chk("t2_error_lit", {error, done, cpu_hold, words}, {1'b1, 1'b0, 1'b1, 7'd2});

        // Test 3: illegal lengths.
        fr = '{8'h00};
        run_frame("t3a", fr, -1);
        fr = '{8'h41};
        run_frame("t3b", fr, -1);
        chk("t3b_error_lit", error, 1);

        // Test 4: full-depth load, with a start pulse mid-frame that must be ignored.
        fr = '{8'h40};
        cs = 8'h00;
        for (int i = 0; i < 256; i++) begin
            fr.push_back(8'((i*37 + 5) & 255));
            cs ^= 8'((i*37 + 5) & 255);
        end
        fr.push_back(cs);
        run_frame("t4", fr, 1);
        chk("t4_words_lit", {done, words}, {1'b1, 7'd64});
        chk("t4_mem0_lit", tbmem[0], 32'h052A4F74);
        chk("t4_mem63_lit", tbmem[63], 32'h7196BBE0);

        // Test 5: transfer on the timeout cycle wins, then a full stall times out.
        pulse_start();
        send_byte(8'h01);
        send_byte(8'hAA);
        byte_valid = 1'b0;
        repeat (TIMEOUT - 1) begin @(posedge clk); #1; end
        send_byte(8'hBB);
        byte_valid = 1'b0;
        chk("t5_xfer_wins", error, 0);
        c = 0;
        while (!error && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk("t5_tmo_cycles", c, TIMEOUT);
        chk("t5_tmo_flags", {error, done, cpu_hold}, 3'b101);
        fr = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        run_frame("t5_retry", fr, -1);
        chk("t5_retry_done", done, 1);

        // Test 6: reset lands on the edge that would have produced mem_we.
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        byte_data  = 8'h44;
        byte_valid = 1'b1;
        reset      = 1'b1;
        @(posedge clk); #1;
        reset      = 1'b0;
        byte_valid = 1'b0;
        chk("t6_reset_outputs",
            {byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, words}, 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("t6_no_we", mem_we, 0);
        fr = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};
        run_frame("t6_reload", fr, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
